// File: rtl/uart_rx_axil_regs_if.sv
// AXI-Lite slave bus bundle for the UART receiver register block.
// master drives requests, slave returns handshakes and responses.
interface uart_rx_axil_regs_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] s_axil_awaddr;
  logic                  s_axil_awvalid;
  logic                  s_axil_awready;
  logic [31:0]           s_axil_wdata;
  logic [3:0]            s_axil_wstrb;
  logic                  s_axil_wvalid;
  logic                  s_axil_wready;
  logic [1:0]            s_axil_bresp;
  logic                  s_axil_bvalid;
  logic                  s_axil_bready;
  logic [ADDR_WIDTH-1:0] s_axil_araddr;
  logic                  s_axil_arvalid;
  logic                  s_axil_arready;
  logic [31:0]           s_axil_rdata;
  logic [1:0]            s_axil_rresp;
  logic                  s_axil_rvalid;
  logic                  s_axil_rready;

  modport master (
    output s_axil_awaddr,
    output s_axil_awvalid,
    input  s_axil_awready,
    output s_axil_wdata,
    output s_axil_wstrb,
    output s_axil_wvalid,
    input  s_axil_wready,
    input  s_axil_bresp,
    input  s_axil_bvalid,
    output s_axil_bready,
    output s_axil_araddr,
    output s_axil_arvalid,
    input  s_axil_arready,
    input  s_axil_rdata,
    input  s_axil_rresp,
    input  s_axil_rvalid,
    output s_axil_rready
  );

  modport slave (
    input  s_axil_awaddr,
    input  s_axil_awvalid,
    output s_axil_awready,
    input  s_axil_wdata,
    input  s_axil_wstrb,
    input  s_axil_wvalid,
    output s_axil_wready,
    output s_axil_bresp,
    output s_axil_bvalid,
    input  s_axil_bready,
    input  s_axil_araddr,
    input  s_axil_arvalid,
    output s_axil_arready,
    output s_axil_rdata,
    output s_axil_rresp,
    output s_axil_rvalid,
    input  s_axil_rready
  );
endinterface

// File: rtl/uart_rx_axil_regs.sv
// AXI-Lite register front end for a UART receiver FIFO.
// Define UART_RX_IRQ_EN to add the IRQ_EN register and irq output.
module uart_rx_axil_regs #(
  parameter int          ADDR_WIDTH       = 4,
  parameter int          DATA_WIDTH       = 8,
  parameter logic [15:0] PRESCALE_DEFAULT = 16'd868
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_axil_regs_if.slave    axil,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic                  rx_ack,
  input  logic                  rx_busy,
  input  logic                  rx_overrun_error,
  input  logic                  rx_framing_error,
  output logic [15:0]           prescale,
  output logic                  irq
);

  localparam logic [1:0] A_RXDATA = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_PRESC  = 2'd2;
  localparam logic [1:0] A_IRQEN  = 2'd3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic [15:0] prescale_q;
  logic        ovr_q;
  logic        frm_q;
  logic        ovr_in_q;
  logic        frm_in_q;

  logic        wr_hs;
  logic        rd_hs;
  logic [1:0]  wsel;
  logic [1:0]  rsel;

  logic        ps_wr;
  logic        ps_bad;
  logic [15:0] ps_new;

  logic        st_wr;
  logic        ovr_set;
  logic        frm_set;
  logic        ovr_clr;
  logic        frm_clr;

  logic        r_rx;
  logic        r_st;
  logic        r_ps;
  logic        r_ie;
  logic [31:0] rx_word;
  logic [31:0] ie_word;
  logic [31:0] rd_word;

  assign wsel = axil.s_axil_awaddr[3:2];
  assign rsel = axil.s_axil_araddr[3:2];

  // Handshakes are held off while reset is asserted.
  assign wr_hs = !rst
              && axil.s_axil_awvalid
              && axil.s_axil_wvalid
              && !bvalid_q;

  assign axil.s_axil_awready = wr_hs;
  assign axil.s_axil_wready  = wr_hs;
  assign axil.s_axil_arready = !rst && !rvalid_q;

  assign rd_hs = axil.s_axil_arvalid
              && axil.s_axil_arready;

  assign axil.s_axil_bvalid = bvalid_q;
  assign axil.s_axil_bresp  = bresp_q;
  assign axil.s_axil_rvalid = rvalid_q;
  assign axil.s_axil_rresp  = rresp_q;
  assign axil.s_axil_rdata  = rdata_q;

  assign prescale = prescale_q;

  // The FIFO head is popped in the same cycle it is captured.
  assign rx_ack = rd_hs
               && (rsel == A_RXDATA)
               && rx_ready;

  always_comb begin
    ps_new = prescale_q;
    if (axil.s_axil_wstrb[0]) begin
      ps_new[7:0] = axil.s_axil_wdata[7:0];
    end
    if (axil.s_axil_wstrb[1]) begin
      ps_new[15:8] = axil.s_axil_wdata[15:8];
    end
  end

  assign ps_wr  = wr_hs && (wsel == A_PRESC);
  assign ps_bad = ps_wr && (ps_new < 16'd2);

  assign st_wr = wr_hs
              && (wsel == A_STATUS)
              && axil.s_axil_wstrb[0];

  assign ovr_clr = st_wr && axil.s_axil_wdata[2];
  assign frm_clr = st_wr && axil.s_axil_wdata[3];

  assign ovr_set = rx_overrun_error && !ovr_in_q;
  assign frm_set = rx_framing_error && !frm_in_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else if (wr_hs) begin
      bvalid_q <= 1'b1;
      bresp_q  <= ps_bad ? SLVERR : OKAY;
    end else if (axil.s_axil_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (rd_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= OKAY;
      rdata_q  <= rd_word;
    end else if (axil.s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q <= PRESCALE_DEFAULT;
    end else if (ps_wr && !ps_bad) begin
      prescale_q <= ps_new;
    end
  end

  // A new error edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_in_q <= 1'b0;
      frm_in_q <= 1'b0;
      ovr_q    <= 1'b0;
      frm_q    <= 1'b0;
    end else begin
      ovr_in_q <= rx_overrun_error;
      frm_in_q <= rx_framing_error;
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
      if (frm_set) begin
        frm_q <= 1'b1;
      end else if (frm_clr) begin
        frm_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_IRQ_EN
  logic [1:0] irq_en_q;
  logic       irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 2'b00;
    end else if (wr_hs
              && (wsel == A_IRQEN)
              && axil.s_axil_wstrb[0]) begin
      irq_en_q <= axil.s_axil_wdata[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (irq_en_q[0] && rx_ready)
            || (irq_en_q[1] && (ovr_q || frm_q));
    end
  end

  assign irq     = irq_q;
  assign ie_word = {30'd0, irq_en_q};
`else
  assign irq     = 1'b0;
  assign ie_word = '0;
`endif

  always_comb begin
    rx_word = '0;
    if (rx_ready) begin
      rx_word[DATA_WIDTH-1:0] = rx_data;
    end
    rx_word[8] = rx_ready;
  end

  assign r_rx = (rsel == A_RXDATA);
  assign r_st = (rsel == A_STATUS);
  assign r_ps = (rsel == A_PRESC);
  assign r_ie = (rsel == A_IRQEN);

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      r_rx:    rd_word = rx_word;
      r_st:    rd_word = {28'd0, frm_q, ovr_q,
                          rx_busy, rx_ready};
      r_ps:    rd_word = {16'd0, prescale_q};
      r_ie:    rd_word = ie_word;
      default: rd_word = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{axil.s_axil_wdata[31:16],
                         axil.s_axil_wstrb[3:2],
                         axil.s_axil_awaddr[ADDR_WIDTH-1:0],
                         axil.s_axil_araddr[ADDR_WIDTH-1:0]};

endmodule

// File: doc/uart_rx_axil_regs.md
UART_RX_AXIL_REGS -- requirements
Module: uart_rx_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, AXI-Lite byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, UART character width.
REQ-003 SHALL have parameter PRESCALE_DEFAULT, default 16'd868, clocks per UART bit after reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have AXI-Lite write ports: s_axil_awaddr in ADDR_WIDTH; s_axil_awvalid in 1; s_axil_awready out 1; s_axil_wdata in 32; s_axil_wstrb in 4; s_axil_wvalid in 1; s_axil_wready out 1; s_axil_bresp out 2; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-007 SHALL have AXI-Lite read ports: s_axil_araddr in ADDR_WIDTH; s_axil_arvalid in 1; s_axil_arready out 1; s_axil_rdata out 32; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1.
REQ-008 SHALL have UART-side ports: rx_data in DATA_WIDTH, FIFO head (first-word fall-through); rx_ready in 1, FIFO non-empty; rx_ack out 1, one-cycle pop; rx_busy in 1; rx_overrun_error in 1; rx_framing_error in 1 (both sticky at source); prescale out 16, clocks per bit.
REQ-009 SHALL have port irq  output  1  level interrupt (only meaningful with UART_RX_IRQ_EN).

Function
REQ-010 Register map (address bits [3:2]): 0x0 RXDATA RO; 0x4 STATUS; 0x8 PRESCALE RW; 0xC IRQ_EN RW.
REQ-011 RXDATA read: rdata[8]=rx_ready, rdata[DATA_WIDTH-1:0]=rx_data if rx_ready else 0; other bits 0.
REQ-012 RXDATA read with rx_ready=1 SHALL pulse rx_ack for exactly the AR handshake cycle, capturing rx_data in the same cycle; with rx_ready=0, no rx_ack.
REQ-013 STATUS: [0] rx_ready, [1] rx_busy, [2] OVR sticky, [3] FRM sticky; others 0.
REQ-014 OVR/FRM SHALL set on a rising edge (registered 0->1) of rx_overrun_error/rx_framing_error; writing 1 to the bit (wstrb[0]=1) clears it; set wins over a clear in the same cycle.
REQ-015 PRESCALE: bits [15:0] drive prescale; bytes written per wstrb[1:0]; upper bits read 0.
REQ-016 A PRESCALE write whose resulting value is below 2 SHALL leave the register unchanged and return bresp=2'b10 (SLVERR); all other writes return 2'b00.
REQ-017 Unmapped or RO targets: writes ignored, bresp OKAY; reads of unmapped addresses return 0, rresp OKAY.
REQ-018 Write: awready=wready=1 only in a cycle where awvalid, wvalid and !bvalid all hold; register update in that cycle; bvalid set next cycle, held until bready.
REQ-019 Read: arready=!rvalid; rdata/rresp registered on AR handshake, rvalid set next cycle, held stable until rready.
REQ-020 Read and write handshakes in the same cycle SHALL both complete independently; a same-cycle W1C and STATUS read returns pre-clear value.

Reset
REQ-021 On rst: awready=wready=arready=0 for that cycle, bvalid=rvalid=0, bresp=rresp=0, rdata=0, rx_ack=0, OVR=FRM=0, edge registers=0, prescale=PRESCALE_DEFAULT, IRQ_EN=0, irq=0.
REQ-022 Reset mid-transaction SHALL abandon any pending B/R response without issuing it and without popping.

Configuration
REQ-023 Macro UART_RX_IRQ_EN defined: IRQ_EN [0] data-ready enable, [1] error enable; irq registered = (IRQ_EN[0]&rx_ready)|(IRQ_EN[1]&(OVR|FRM)), one-cycle latency.
REQ-024 UART_RX_IRQ_EN undefined: IRQ_EN register absent (reads 0, writes ignored), irq tied 0.

Verification
REQ-025 After reset, read 0x8 -> rdata=0x364, rresp=0; read 0x4 with idle UART -> 0x0.
REQ-026 rx_ready=1, rx_data=0xA5, read 0x0 -> rdata=0x1A5, rx_ack high exactly one cycle; rx_ready=0 then read 0x0 -> rdata=0x000, no rx_ack.
REQ-027 Raise rx_framing_error -> STATUS=0x8; write 0x4 data 0x8 -> STATUS=0x0 despite input still high; write coinciding with new overrun edge -> OVR stays 1.
REQ-028 Write 0x8 data 0x1B2 wstrb 0x3 -> prescale=0x1B2, bresp=0; write 0x1 -> bresp=2'b10, prescale remains 0x1B2.
REQ-029 Hold rready=0 two cycles after read of 0x8 -> rvalid and rdata stable, arready=0; bready=0 -> awready/wready stay 0 for next write.
REQ-030 With UART_RX_IRQ_EN: IRQ_EN=0x1, rx_ready 0->1 -> irq=1 next cycle; IRQ_EN=0x0 -> irq=0; without macro irq=0 throughout.
